regfile_mp: RTL and testbench

//  Parametrised multi-port GPR file for the pipeline's ID/WB stages; successor to the 2R1W regfile.

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_rd_port.sv | 53 +++++
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Contents: scrub FSM state type and the active levels of reset,
// write-enable and read-enable strobes.
package regfile_mp_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port of regfile_mp.
// Ports:
//   en       read allowed (port enable, not in reset, scrub finished)
//   addr     read address
//   word     array contents at addr
//   wr_en    per write port: write will commit this cycle
//   wr_addr  write addresses, port w at [w*ADDR_W +: ADDR_W]
//   wr_data  write data, port w at [w*DATA_W +: DATA_W]
//   wr_be    byte enables, port w at [w*DATA_W/8 +: DATA_W/8]
//   data     read result
module regfile_mp_rd_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          word,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*DATA_W/8-1:0] wr_be,
  output logic [DATA_W-1:0]          data
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = word;
    // Ascending port order so the higher-index port overrides per byte,
    // matching how the array commits colliding writes.
    if (BYPASS != 0) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[w*NB + b]) begin
              merged[b*8 +: 8] = wr_data[(w*NB + b)*8 +: 8];
            end
          end
        end
      end
    end
    data = '0;
    if (en && !((ZERO_REG != 0) && (addr == '0))) begin
      data = merged;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports, NUM_WR byte-enabled
// write ports (higher index wins per byte), optional write-to-read bypass,
// zero-scrub of the whole array after reset, registered collision flag.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   re/raddr      per read port enable and address
//   rdata         per read port data (combinational)
//   we/waddr      per write port enable and address
//   wdata/wbe     per write port data and byte enables
//   init_busy     high while the array is being scrubbed
//   wr_collision  one-cycle pulse after both write ports hit one writable address
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_WR*DATA_W/8-1:0] wbe,
  output logic                       init_busy,
  output logic                       wr_collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];
  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] scrub_cnt;
  logic              run;
  logic [NUM_WR-1:0] wr_ok;
  logic              collision;

  assign run       = (state == RF_RUN) && (rst != RST_ENABLE);
  assign init_busy = (state == RF_INIT);

  always_comb begin
    wr_ok = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wr_ok[w] = run && (we[w] == WRITE_ENABLE) &&
                 !((ZERO_REG != 0) && (waddr[w*ADDR_W +: ADDR_W] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= RF_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == RF_INIT) && (scrub_cnt == '1)) begin
      state_nxt = RF_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      scrub_cnt <= '0;
    end else if (state == RF_INIT) begin
      scrub_cnt <= scrub_cnt + 1'b1;
    end
  end

  // Later ports are assigned last, so their enabled bytes win on collisions.
  always_ff @(posedge clk) begin
    if ((rst != RST_ENABLE) && (state == RF_INIT)) begin
      regs[scrub_cnt] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (wbe[w*NB + b]) begin
              regs[waddr[w*ADDR_W +: ADDR_W]][b*8 +: 8] <= wdata[(w*NB + b)*8 +: 8];
            end
          end
        end
      end
    end
  end

  generate
    if (NUM_WR > 1) begin : g_coll
      assign collision = wr_ok[0] && wr_ok[1] &&
                         (waddr[0 +: ADDR_W] == waddr[ADDR_W +: ADDR_W]);
    end else begin : g_no_coll
      assign collision = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_collision <= 1'b0;
    end else begin
      wr_collision <= collision;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_mp_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .en     (run && (re[g] == READ_ENABLE)),
      .addr   (raddr[g*ADDR_W +: ADDR_W]),
      .word   (regs[raddr[g*ADDR_W +: ADDR_W]]),
      .wr_en  (wr_ok),
      .wr_addr(waddr),
      .wr_data(wdata),
      .wr_be  (wbe),
      .data   (rdata[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default 2R2W bypassing instance checked every cycle
// against a behavioural model, plus a 4R1W non-bypassing instance.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        re;
  logic [2*AW-1:0]   raddr;
  logic [2*DW-1:0]   rdata;
  logic [1:0]        we;
  logic [2*AW-1:0]   waddr;
  logic [2*DW-1:0]   wdata;
  logic [7:0]        wbe;
  logic              init_busy, wr_collision;

  logic [3:0]        re4;
  logic [4*AW-1:0]   raddr4;
  logic [4*DW-1:0]   rdata4;
  logic [0:0]        we1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic [3:0]        wbe1;
  logic              busy4, coll4;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .init_busy(init_busy), .wr_collision(wr_collision)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
  ) u_np (
    .clk(clk), .rst(rst), .re(re4), .raddr(raddr4), .rdata(rdata4),
    .we(we1), .waddr(waddr1), .wdata(wdata1), .wbe(wbe1),
    .init_busy(busy4), .wr_collision(coll4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of the default instance.
  logic [31:0] m_regs [32];
  bit          m_busy;
  int          m_cnt;
  bit          m_coll;

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (base & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] exp_read(input int p);
    logic [4:0]  a;
    logic [31:0] v;
    a = raddr[p*AW +: AW];
    if (rst || m_busy || !re[p] || a == 5'd0) return 32'h0;
    v = m_regs[a];
    for (int w = 0; w < 2; w++)
      if (we[w] && waddr[w*AW +: AW] == a) v = merge(v, wdata[w*DW +: DW], wbe[w*4 +: 4]);
    return v;
  endfunction

  task automatic cycle(input string tag);
    logic [4:0] a;
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      check($sformatf("%s_rd%0d", tag, p), rdata[p*DW +: DW], exp_read(p));
    check($sformatf("%s_busy", tag), {31'b0, init_busy}, {31'b0, m_busy});
    check($sformatf("%s_coll", tag), {31'b0, wr_collision}, {31'b0, m_coll});
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1; m_cnt = 0; m_coll = 1'b0;
    end else if (m_busy) begin
      m_regs[m_cnt] = 32'h0;
      m_coll = 1'b0;
      if (m_cnt == 31) m_busy = 1'b0;
      m_cnt++;
    end else begin
      m_coll = we[0] && we[1] && (waddr[4:0] == waddr[9:5]) && (waddr[4:0] != 5'd0);
      for (int w = 0; w < 2; w++) begin
        a = waddr[w*AW +: AW];
        if (we[w] && a != 5'd0) m_regs[a] = merge(m_regs[a], wdata[w*DW +: DW], wbe[w*4 +: 4]);
      end
    end
    #1;
  endtask

  task automatic idle();
    re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0; wbe = '0;
    re4 = '0; raddr4 = '0; we1 = '0; waddr1 = '0; wdata1 = '0; wbe1 = '0;
  endtask

  task automatic rand_traffic();
    re = 2'($urandom);
    raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    we = 2'($urandom);
    waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    wdata = {$urandom, $urandom};
    wbe = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_busy = 1'b1; m_cnt = 0; m_coll = 1'b0;
    @(posedge clk); #1;

    // Reset and scrub; writes during INIT are random and must be lost.
    re = 2'b11; raddr = {5'd9, 5'd3};
    cycle("rst");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rand_traffic();
      #3 check("scrub_busy_const", {31'b0, init_busy}, 32'd1);
      cycle("scrub");
    end
    idle(); re = 2'b11; raddr = {5'd31, 5'd1};
    #3 check("post_busy_const", {31'b0, init_busy}, 32'd0);
    check("post_rd0_const", rdata[31:0], 32'h0);
    cycle("post");

    // Write with same-cycle bypass, then byte-enable update.
    idle(); we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF; wbe[3:0] = 4'hF;
    re = 2'b01; raddr[4:0] = 5'd5;
    #3 check("t2_bypass", rdata[31:0], 32'hDEADBEEF);
    cycle("t2a");
    idle(); re = 2'b01; raddr[4:0] = 5'd5;
    #3 check("t2_read", rdata[31:0], 32'hDEADBEEF);
    cycle("t2b");
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'h0000AA00; wbe[3:0] = 4'h2;
    #3 check("t2_byte_byp", rdata[31:0], 32'hDEADAAEF);
    cycle("t2c");
    idle(); re = 2'b10; raddr[9:5] = 5'd5;
    #3 check("t2_byte_rd", rdata[63:32], 32'hDEADAAEF);
    cycle("t2d");

    // Collision on reg7, then on reg0 (no flag).
    idle(); we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22222222, 32'h11111111};
    wbe = {4'h3, 4'hF};
    cycle("t3a");
    idle(); re = 2'b10; raddr[9:5] = 5'd7;
    #3 check("t3_merge", rdata[63:32], 32'h11112222);
    check("t3_flag", {31'b0, wr_collision}, 32'd1);
    cycle("t3b");
    idle(); we = 2'b11; waddr = '0; wdata = {32'h33333333, 32'h44444444}; wbe = 8'hFF;
    #3 check("t3_flag_drop", {31'b0, wr_collision}, 32'd0);
    cycle("t3c");
    idle();
    #3 check("t3_r0_noflag", {31'b0, wr_collision}, 32'd0);
    cycle("t3d");

    // Zero register and read enable gating.
    we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFFFFFF; wbe[3:0] = 4'hF;
    re = 2'b11; raddr = '0;
    #3 check("t4_r0_p0", rdata[31:0], 32'h0);
    check("t4_r0_p1", rdata[63:32], 32'h0);
    cycle("t4a");
    idle(); re = 2'b01; raddr = {5'd7, 5'd7};
    #3 check("t4_en", rdata[31:0], 32'h11112222);
    check("t4_dis", rdata[63:32], 32'h0);
    cycle("t4b");

    // 4R1W without bypass: old value same cycle, new value next cycle.
    idle(); we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h12345678; wbe1 = 4'hF;
    re4 = 4'hF; raddr4 = {4{5'd3}};
    #3 for (int p = 0; p < 4; p++) check($sformatf("t6_old%0d", p), rdata4[p*DW +: DW], 32'h0);
    cycle("t6a");
    we1 = 1'b0;
    #3 for (int p = 0; p < 4; p++) check($sformatf("t6_new%0d", p), rdata4[p*DW +: DW], 32'h12345678);
    check("t6_coll", {31'b0, coll4}, 32'd0);
    check("t6_busy", {31'b0, busy4}, 32'd0);
    cycle("t6b");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle();
      rand_traffic();
      cycle("rnd");
    end

    // Reset mid-scrub at scrub_cnt==10, INIT writes lost, full scrub again.
    idle(); rst = 1'b1;
    cycle("t5_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_traffic();
      cycle("t5_part");
    end
    idle(); rst = 1'b1;
    cycle("t5_rst2");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rand_traffic();
      #3 check("t5_busy_const", {31'b0, init_busy}, 32'd1);
      cycle("t5_scrub");
    end
    for (int a = 0; a < 32; a++) begin
      idle(); re = 2'b11; raddr = {5'(31 - a), 5'(a)};
      #3 check($sformatf("t5_zero%0d", a), rdata[31:0], 32'h0);
      cycle("t5_sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
